prim_executor: RTL and testbench

PRIM_EXECUTOR -- requirements
Module: prim_executor

---
 rtl/prim_executor_pkg.sv | 47 ++++
 rtl/prim_executor_alu.sv | 44 ++++
 rtl/prim_executor.sv | 249 ++++++++++++++++++++++++
 tb/tb_prim_executor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_executor_pkg.sv
// prim_executor_pkg: shared definitions for the packet primitive executor.
//   - opcode values, FSM state encoding, error codes
//   - default L2 header skip (HDR_BASE_DEFAULT)
//   - width helpers used by the executor and its ALU
package prim_executor_pkg;

  localparam int HDR_BASE_DEFAULT = 14;

  localparam logic [5:0] OP_NOP        = 6'h00;
  localparam logic [5:0] OP_ADD        = 6'h01;
  localparam logic [5:0] OP_SET_FIELD  = 6'h02;
  localparam logic [5:0] OP_COPY_FIELD = 6'h03;
  localparam logic [5:0] OP_SET_PORT   = 6'h04;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_STEPS  = 2'd2;
  localparam logic [1:0] ERR_WIDTH  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_F0   = 4'd1,
    ST_F1   = 4'd2,
    ST_F2   = 4'd3,
    ST_EX   = 4'd4,
    ST_RD   = 4'd5,
    ST_RW   = 4'd6,
    ST_WR   = 4'd7,
    ST_DONE = 4'd8
  } state_e;

  // Byte mask for a field of 1..4 bytes; out-of-range widths never reach
  // the datapath, so they simply get the full word.
  function automatic logic [31:0] width_mask(input logic [3:0] w);
    case (w)
      4'd1:    return 32'h0000_00FF;
      4'd2:    return 32'h0000_FFFF;
      4'd3:    return 32'h00FF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic width_ok(input logic [3:0] w);
    return (w >= 4'd1) && (w <= 4'd4);
  endfunction

endpackage

// File: rtl/prim_executor_alu.sv
// prim_alu: combinational field datapath for prim_executor.
//   a_i      : field value read from memory (masked to width here)
//   b_i      : second operand (immediate for ADD, value to pass otherwise)
//   width_i  : field width in bytes, 1..4
//   add_en_i : 1 = a + b, 0 = pass b
//   res_o    : result masked to width_i*8 bits
// Build option: PRIM_EXEC_SAT_ADD_EN makes ADD saturate (max on carry,
// 0 on borrow) instead of wrapping.
module prim_alu
  import prim_executor_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  width_i,
  input  logic        add_en_i,
  output logic [31:0] res_o
);

  logic [31:0] mask;
`ifdef PRIM_EXEC_SAT_ADD_EN
  logic [33:0] sum;
`endif

  always_comb begin
    mask  = width_mask(width_i);
    res_o = b_i & mask;
`ifdef PRIM_EXEC_SAT_ADD_EN
    // Zero-extended field plus sign-extended imm; bit 33 flags a negative result.
    sum = {2'b00, a_i & mask} + {{2{b_i[31]}}, b_i};
    if (add_en_i) begin
      if (sum[33])
        res_o = 32'h0;
      else if (sum[32:0] > {1'b0, mask})
        res_o = mask;
      else
        res_o = sum[31:0] & mask;
    end
`else
    if (add_en_i)
      res_o = ((a_i & mask) + b_i) & mask;
`endif
  end

endmodule

// File: rtl/prim_executor.sv
// prim_executor: fetches 64-bit primitives from memory and applies them to
// packet header fields (ADD, SET_FIELD, COPY_FIELD, SET_PORT, NOP).
// Ports:
//   clk, rst (async, active low)
//   start_i, start_addr_i           : run request level, first instruction
//   mem_ce_o/we_o/addr_o/width_o/data_o, mem_data_i : registered memory port,
//                                     read data valid the cycle after ce
//   done_o, err_o, err_code_o       : completion and error status
//   port_o, port_vld_o, steps_o     : egress port and retired instructions
// Build option: PRIM_EXEC_SAT_ADD_EN (saturating ADD, see prim_alu).
//
// state | meaning
// IDLE  | wait for start_i, latch PC
// F0    | present PC (high instruction word)
// F1    | present PC+4, capture high word
// F2    | capture low word, PC += 8
// EX    | budget check, decode, dispatch
// RD    | present field read
// RW    | capture field read data
// WR    | present field write
// DONE  | hold done_o until start_i drops
module prim_executor
  import prim_executor_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int HDR_BASE  = HDR_BASE_DEFAULT,
  parameter int MAX_STEPS = 64,
  parameter int PORT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_width_o,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [PORT_W-1:0] port_o,
  output logic              port_vld_o,
  output logic [9:0]        steps_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fld_addr_q, fld_addr_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       imm_q, imm_d;
  logic [5:0]        src_q, src_d;
  logic [3:0]        wid_q, wid_d;
  logic [5:0]        dst_q, dst_d;
  logic [9:0]        steps_q, steps_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic              port_vld_q, port_vld_d;
  logic              done_q, done_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_width_q, mem_width_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [31:0]       alu_res;

  // One ALU serves all writes: SET passes imm, COPY passes the read data,
  // ADD sums the read data with imm.
  prim_alu u_alu (
    .a_i      (mem_data_i),
    .b_i      ((op_q == OP_COPY_FIELD) ? mem_data_i : imm_q),
    .width_i  (wid_q),
    .add_en_i (op_q == OP_ADD),
    .res_o    (alu_res)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fld_addr_d  = fld_addr_q;
    op_d        = op_q;
    imm_d       = imm_q;
    src_d       = src_q;
    wid_d       = wid_q;
    dst_d       = dst_q;
    steps_d     = steps_q;
    err_code_d  = err_code_q;
    port_d      = port_q;
    port_vld_d  = port_vld_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pc_d       = start_addr_i;
          steps_d    = 10'd0;
          err_code_d = ERR_NONE;
          port_vld_d = 1'b0;
          state_d    = ST_F0;
        end
      end
      ST_F0: state_d = ST_F1;
      ST_F1: begin
        op_d    = mem_data_i[31:26];
        imm_d   = {{6{mem_data_i[25]}}, mem_data_i[25:0]};
        state_d = ST_F2;
      end
      ST_F2: begin
        src_d   = mem_data_i[27:22];
        wid_d   = mem_data_i[19:16];
        dst_d   = mem_data_i[11:6];
        pc_d    = pc_q + ADDR_W'(8);
        state_d = ST_EX;
      end
      ST_EX: begin
        if (steps_q == 10'(MAX_STEPS)) begin
          err_code_d = ERR_STEPS;
          state_d    = ST_DONE;
        end else begin
          steps_d = steps_q + 10'd1;
          case (op_q)
            OP_NOP: state_d = ST_DONE;
            OP_SET_PORT: begin
              port_d     = imm_q[PORT_W-1:0];
              port_vld_d = 1'b1;
              state_d    = ST_F0;
            end
            OP_ADD, OP_SET_FIELD, OP_COPY_FIELD: begin
              if (!width_ok(wid_q)) begin
                err_code_d = ERR_WIDTH;
                state_d    = ST_DONE;
              end else if (op_q == OP_SET_FIELD) begin
                fld_addr_d = ADDR_W'(HDR_BASE) + ADDR_W'(dst_q);
                state_d    = ST_WR;
              end else begin
                fld_addr_d = ADDR_W'(HDR_BASE) + ADDR_W'(src_q);
                state_d    = ST_RD;
              end
            end
            default: begin
              err_code_d = ERR_OPCODE;
              state_d    = ST_DONE;
            end
          endcase
        end
      end
      ST_RD: state_d = ST_RW;
      ST_RW: begin
        if (op_q == OP_COPY_FIELD)
          fld_addr_d = ADDR_W'(HDR_BASE) + ADDR_W'(dst_q);
        state_d = ST_WR;
      end
      ST_WR: state_d = ST_F0;
      ST_DONE: begin
        if (!start_i)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Memory and done outputs are registered, so they follow the next state.
    mem_ce_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_width_d = 4'd0;
    mem_data_d  = 32'h0;
    done_d      = (state_d == ST_DONE);
    case (state_d)
      ST_F0: begin
        mem_ce_d    = 1'b1;
        mem_addr_d  = pc_d;
        mem_width_d = 4'd4;
      end
      ST_F1: begin
        mem_ce_d    = 1'b1;
        mem_addr_d  = pc_d + ADDR_W'(4);
        mem_width_d = 4'd4;
      end
      ST_RD: begin
        mem_ce_d    = 1'b1;
        mem_addr_d  = fld_addr_d;
        mem_width_d = wid_d;
      end
      ST_WR: begin
        mem_ce_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = fld_addr_d;
        mem_width_d = wid_d;
        mem_data_d  = alu_res;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      fld_addr_q  <= '0;
      op_q        <= 6'd0;
      imm_q       <= 32'h0;
      src_q       <= 6'd0;
      wid_q       <= 4'd0;
      dst_q       <= 6'd0;
      steps_q     <= 10'd0;
      err_code_q  <= ERR_NONE;
      port_q      <= '0;
      port_vld_q  <= 1'b0;
      done_q      <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_width_q <= 4'd0;
      mem_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fld_addr_q  <= fld_addr_d;
      op_q        <= op_d;
      imm_q       <= imm_d;
      src_q       <= src_d;
      wid_q       <= wid_d;
      dst_q       <= dst_d;
      steps_q     <= steps_d;
      err_code_q  <= err_code_d;
      port_q      <= port_d;
      port_vld_q  <= port_vld_d;
      done_q      <= done_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_width_q <= mem_width_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign mem_ce_o    = mem_ce_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_width_o = mem_width_q;
  assign mem_data_o  = mem_data_q;
  assign done_o      = done_q;
  assign err_code_o  = err_code_q;
  assign err_o       = (err_code_q != ERR_NONE);
  assign port_o      = port_q;
  assign port_vld_o  = port_vld_q;
  assign steps_o     = steps_q;

endmodule

// File: tb/tb_prim_executor.sv
// tb_prim_executor: directed programs against prim_executor (MAX_STEPS=4)
// with a byte-wide memory model and hand-computed expected results.
module tb_prim_executor;
  import prim_executor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_addr = 32'h0;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_width;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        done, err;
  logic [1:0]  err_code;
  logic [7:0]  port;
  logic        port_vld;
  logic [9:0]  steps;

  int total = 0;
  int bad   = 0;
  int wr_beats = 0;
  int beats0;

  logic [7:0]  mem [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = 12'h0;
  logic [31:0] bd_data = 32'h0;

`ifdef PRIM_EXEC_SAT_ADD_EN
  localparam logic [31:0] EXP_ADD_POS = 32'h0000_00FF;
  localparam logic [31:0] EXP_ADD_NEG = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_ADD_POS = 32'h0000_0001;
  localparam logic [31:0] EXP_ADD_NEG = 32'h0000_FFFD;
`endif

  prim_executor #(.MAX_STEPS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .start_addr_i (start_addr),
    .mem_ce_o     (mem_ce),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_width_o  (mem_width),
    .mem_data_o   (mem_wdata),
    .mem_data_i   (mem_rdata),
    .done_o       (done),
    .err_o        (err),
    .err_code_o   (err_code),
    .port_o       (port),
    .port_vld_o   (port_vld),
    .steps_o      (steps)
  );

  always #5 clk = ~clk;

  // Byte-addressed little-endian memory, 1-cycle read latency, plus a
  // backdoor word port used only while the DUT is idle.
  always @(posedge clk) begin
    if (bd_we) begin
      for (int i = 0; i < 4; i++)
        mem[bd_addr + 12'(i)] <= bd_data[8*i +: 8];
    end
    if (mem_ce && mem_we) begin
      wr_beats <= wr_beats + 1;
      for (int i = 0; i < 4; i++)
        if (i < int'(mem_width))
          mem[12'(mem_addr + 32'(i))] <= mem_wdata[8*i +: 8];
    end else if (mem_ce) begin
      for (int i = 0; i < 4; i++)
        mem_rdata[8*i +: 8] <= (i < int'(mem_width)) ? mem[12'(mem_addr + 32'(i))] : 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] insn(input logic [5:0] op, input logic [25:0] imm,
                                       input logic [5:0] src, input logic [3:0] w,
                                       input logic [5:0] dst);
    logic [63:0] r;
    r = 64'h0;
    r[63:58] = op;
    r[57:32] = imm;
    r[27:22] = src;
    r[19:16] = w;
    r[11:6]  = dst;
    return r;
  endfunction

  task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    bd_addr = a[11:0];
    bd_data = w;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic put_insn(input logic [31:0] a, input logic [63:0] v);
    poke_word(a, v[63:32]);
    poke_word(a + 32'd4, v[31:0]);
  endtask

  function automatic logic [31:0] peek_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // Raise start, wait (bounded) for done; start stays high so DONE holds.
  task automatic run_prog(input string tag, input logic [31:0] a);
    int n;
    beats0 = wr_beats;
    @(negedge clk);
    start_addr = a;
    start      = 1'b1;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'h0, done}, 32'h1);
  endtask

  task automatic end_prog(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_fall"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    #12;
    chk("rst_ce",       {31'h0, mem_ce},   32'h0);
    chk("rst_we",       {31'h0, mem_we},   32'h0);
    chk("rst_done",     {31'h0, done},     32'h0);
    chk("rst_err",      {30'h0, err_code}, 32'h0);
    chk("rst_port_vld", {31'h0, port_vld}, 32'h0);
    chk("rst_steps",    {22'h0, steps},    32'h0);
    @(negedge clk);
    rst = 1'b1;

    // SET_PORT 5; NOP
    put_insn(32'h100, insn(OP_SET_PORT, 26'd5, 6'd0, 4'd0, 6'd0));
    put_insn(32'h108, insn(OP_NOP, 26'd0, 6'd0, 4'd0, 6'd0));
    run_prog("port", 32'h100);
    chk("port_val",   {24'h0, port},     32'h5);
    chk("port_vld",   {31'h0, port_vld}, 32'h1);
    chk("port_steps", {22'h0, steps},    32'h2);
    chk("port_err",   {31'h0, err},      32'h0);
    end_prog("port");
    chk("port_hold",  {24'h0, port},     32'h5);

    // ADD width 1, imm 3 on 0xFE at byte 16; byte 17 must survive
    poke_word(32'd16, 32'h0000_AAFE);
    put_insn(32'h200, insn(OP_ADD, 26'd3, 6'd2, 4'd1, 6'd0));
    put_insn(32'h208, insn(OP_NOP, 26'd0, 6'd0, 4'd0, 6'd0));
    run_prog("add", 32'h200);
    chk("add_result", {24'h0, mem[16]},     EXP_ADD_POS);
    chk("add_byte17", {24'h0, mem[17]},     32'hAA);
    chk("add_beats",  wr_beats - beats0,    32'd1);
    chk("add_pv_clr", {31'h0, port_vld},    32'h0);
    end_prog("add");

    // ADD width 2, imm -5 on 0x0002 at byte 40
    poke_word(32'd40, 32'h0000_0002);
    put_insn(32'h240, insn(OP_ADD, 26'h3FF_FFFB, 6'd26, 4'd2, 6'd0));
    put_insn(32'h248, insn(OP_NOP, 26'd0, 6'd0, 4'd0, 6'd0));
    run_prog("addneg", 32'h240);
    chk("addneg_result", peek_word(40), EXP_ADD_NEG);
    end_prog("addneg");

    // COPY 4 bytes 14 -> 20
    poke_word(32'd14, 32'h4433_2211);
    poke_word(32'd20, 32'h0);
    put_insn(32'h300, insn(OP_COPY_FIELD, 26'd0, 6'd0, 4'd4, 6'd6));
    put_insn(32'h308, insn(OP_NOP, 26'd0, 6'd0, 4'd0, 6'd0));
    run_prog("copy", 32'h300);
    chk("copy_data",  peek_word(20),      32'h4433_2211);
    chk("copy_beats", wr_beats - beats0,  32'd1);
    end_prog("copy");

    // Illegal opcode
    put_insn(32'h400, insn(6'h3F, 26'd0, 6'd0, 4'd1, 6'd0));
    run_prog("badop", 32'h400);
    chk("badop_code",  {30'h0, err_code}, 32'h1);
    chk("badop_err",   {31'h0, err},      32'h1);
    chk("badop_beats", wr_beats - beats0, 32'd0);
    end_prog("badop");

    // Width 5 and width 0
    put_insn(32'h700, insn(OP_SET_FIELD, 26'd7, 6'd0, 4'd5, 6'd30));
    run_prog("w5", 32'h700);
    chk("w5_code",  {30'h0, err_code}, 32'h3);
    chk("w5_beats", wr_beats - beats0, 32'd0);
    chk("w5_steps", {22'h0, steps},    32'h1);
    end_prog("w5");
    put_insn(32'h720, insn(OP_COPY_FIELD, 26'd0, 6'd0, 4'd0, 6'd30));
    run_prog("w0", 32'h720);
    chk("w0_code",  {30'h0, err_code}, 32'h3);
    chk("w0_beats", wr_beats - beats0, 32'd0);
    end_prog("w0");

    // Step budget: 10 SET_FIELDs, only 4 may retire
    for (int i = 0; i < 10; i++)
      put_insn(32'h500 + 32'(8*i), insn(OP_SET_FIELD, 26'(i+1), 6'd0, 4'd1, 6'd30));
    run_prog("budget", 32'h500);
    chk("budget_code",  {30'h0, err_code}, 32'h2);
    chk("budget_steps", {22'h0, steps},    32'h4);
    chk("budget_beats", wr_beats - beats0, 32'd4);
    chk("budget_last",  {24'h0, mem[44]},  32'h4);
    end_prog("budget");

    // PC wrap across the top of the address space
    put_insn(32'hFFFF_FFF8, insn(OP_SET_PORT, 26'd9, 6'd0, 4'd0, 6'd0));
    put_insn(32'h0000_0000, insn(OP_NOP, 26'd0, 6'd0, 4'd0, 6'd0));
    run_prog("wrap", 32'hFFFF_FFF8);
    chk("wrap_port",  {24'h0, port},  32'h9);
    chk("wrap_steps", {22'h0, steps}, 32'h2);
    end_prog("wrap");

    // Reset during the WR beat of an ADD abandons the write
    poke_word(32'd48, 32'h0010_0000);
    put_insn(32'h600, insn(OP_ADD, 26'd1, 6'd36, 4'd1, 6'd0));
    put_insn(32'h608, insn(OP_NOP, 26'd0, 6'd0, 4'd0, 6'd0));
    @(negedge clk);
    start_addr = 32'h600;
    start      = 1'b1;
    n = 0;
    while (!mem_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rstwr_we_seen", {31'h0, mem_we}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("rstwr_ce",    {31'h0, mem_ce},  32'h0);
    chk("rstwr_we",    {31'h0, mem_we},  32'h0);
    chk("rstwr_port",  {24'h0, port},    32'h0);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("rstwr_mem",   {24'h0, mem[50]}, 32'h10);
    @(negedge clk);
    rst = 1'b1;
    run_prog("rerun", 32'h100);
    chk("rerun_port",  {24'h0, port},     32'h5);
    chk("rerun_steps", {22'h0, steps},    32'h2);
    chk("rerun_err",   {30'h0, err_code}, 32'h0);
    end_prog("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
